// File: rtl/sys_bus_defs.sv
// ============================================================================
// sys_bus_defs: shared state encoding and default widths for the bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package sys_bus_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam int DEF_ADDR_BITS  = 17;
  localparam int DEF_DATA_BITS  = 32;
  localparam int MAX_RD_LATENCY = 7;
  localparam int CNT_BITS       = 3;

endpackage

`default_nettype wire

// File: rtl/sys_bus_rr_pick.sv
// ============================================================================
// sys_bus_rr_pick: combinational two-way round-robin picker (winner 0 = m0)
// Rev 1.0
// ============================================================================
`default_nettype none

module sys_bus_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sys_bus_arbiter.sv
// ============================================================================
// sys_bus_arbiter: two-master round-robin arbiter for the core-selector bus
// Rev 1.0
// ============================================================================
`default_nettype none

module sys_bus_arbiter
  import sys_bus_defs::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int RD_LATENCY = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 m0_req,
  input  logic                 m0_wr,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [DATA_BITS-1:0] m0_wdata,
  output logic                 m0_ack,
  output logic [DATA_BITS-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_wr,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [DATA_BITS-1:0] m1_wdata,
  output logic                 m1_ack,
  output logic [DATA_BITS-1:0] m1_rdata,
  output logic [ADDR_BITS-1:0] sys_addr,
  output logic                 sys_wr,
  output logic                 sys_rd,
  output logic [DATA_BITS-1:0] sys_write_data,
  input  logic [DATA_BITS-1:0] sys_read_data,
  output logic                 busy
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_rd_latency
      $error("sys_bus_arbiter: RD_LATENCY must be in 1..%0d", MAX_RD_LATENCY);
    end
  endgenerate

  localparam logic [CNT_BITS-1:0] LOAD_CNT = CNT_BITS'(RD_LATENCY - 1);

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic                last_grant;
  logic                grant;
  logic                lat_wr;
  logic                pick_valid;
  logic                pick_winner;
  logic                win_wr;
  logic [ADDR_BITS-1:0] win_addr;
  logic [DATA_BITS-1:0] win_wdata;

  sys_bus_rr_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    win_wr    = m0_wr;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    if (pick_winner) begin
      win_wr    = m1_wr;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  // Strobes and acks are set on the edge entering ISSUE/ACK so they are
  // registered and last exactly one cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      last_grant     <= 1'b1;
      grant          <= 1'b0;
      lat_wr         <= 1'b0;
      sys_addr       <= '0;
      sys_write_data <= '0;
      sys_wr         <= 1'b0;
      sys_rd         <= 1'b0;
      m0_ack         <= 1'b0;
      m1_ack         <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
      busy           <= 1'b0;
    end else begin
      sys_wr <= 1'b0;
      sys_rd <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant          <= pick_winner;
            last_grant     <= pick_winner;
            lat_wr         <= win_wr;
            sys_addr       <= win_addr;
            sys_write_data <= win_wdata;
            sys_wr         <= win_wr;
            sys_rd         <= ~win_wr;
            busy           <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (lat_wr) begin
            m0_ack <= ~grant;
            m1_ack <= grant;
            state  <= ST_ACK;
          end else begin
            cnt   <= LOAD_CNT;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            if (grant) begin
              m1_rdata <= sys_read_data;
            end else begin
              m0_rdata <= sys_read_data;
            end
            m0_ack <= ~grant;
            m1_ack <= grant;
            state  <= ST_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ACK: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
